enqueue_agent_v0_2: RTL and testbench

Parametrised successor enqueue agent for the PIFO scheduler top. Sits between the P4 pipeline output and the per-port buffer/PIFO queues. Decodes the destination from `sume_meta` (tuser) and gates `buffer_wr_en` per beat and `pifo_in_en` per packet. Adds a configurable port count, a choice of multicast policy, a bounded wait-on-full mode, and saturating drop/enqueue statistics.

---
 rtl/enqueue_agent_v0_2.sv | 143 ++++++++++++++
 tb/tb_enqueue_agent_v0_2.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/enqueue_agent_v0_2.sv
// enqueue_agent_v0_2
// Decodes the destination from sume_meta (tuser), decides per packet whether
// to enqueue, wait for space or drop, then gates buffer_wr_en on every beat and
// pifo_in_en on the first accepted beat. Keeps saturating drop/enqueue counters.
module enqueue_agent_v0_2 #(
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_PORTS            = 4,
    parameter int DST_POS              = 24,
    parameter int DROP_POS             = 32,
    parameter int MCAST_MODE           = 0,
    parameter int WAIT_CYCLES          = 0,
    parameter int CNT_WIDTH            = 32
) (
    input  logic                                 axis_aclk,
    input  logic                                 axis_reset,
    input  logic                                 s_axis_tvalid,
    output logic                                 s_axis_tready,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser,
    input  logic                                 s_axis_tlast,
    input  logic [NUM_PORTS:0]                   s_axis_buffer_almost_full,
    input  logic [NUM_PORTS:0]                   s_axis_pifo_full,
    output logic [NUM_PORTS:0]                   m_axis_ctl_pifo_in_en,
    output logic [NUM_PORTS:0]                   m_axis_ctl_buffer_wr_en,
    input  logic                                 stat_clear,
    output logic [(NUM_PORTS+1)*CNT_WIDTH-1:0]   stat_drop_cnt,
    output logic [CNT_WIDTH-1:0]                 stat_meta_drop_cnt,
    output logic [CNT_WIDTH-1:0]                 stat_enq_cnt
);

    localparam int QUEUE_NUM = NUM_PORTS + 1;
    localparam int TW        = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TIMER_INIT = TW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
    localparam logic [TW-1:0] T_ONE      = TW'(1);
    localparam logic [CNT_WIDTH-1:0] C_ONE = CNT_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, WAIT, ENQUEUE, DROP} state_t;

    state_t                 state;
    logic [QUEUE_NUM-1:0]   mask;
    logic                   first;
    logic [TW-1:0]          timer;

    logic [QUEUE_NUM-1:0]   dst, blocked, ok, drop_inc;
    logic [NUM_PORTS-1:0]   cpu_bits;
    logic                   meta_drop, eligible, evaluate;
    logic                   meta_hit, go_enq, give_up;
    logic                   unused_tuser;

    // Only a handful of tuser bits matter; fold the rest away.
    assign unused_tuser = ^s_axis_tuser;

    // Even bits of the dst field are the physical ports; any odd bit means CPU.
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_dst
        assign dst[i]      = s_axis_tuser[DST_POS + 2*i];
        assign cpu_bits[i] = s_axis_tuser[DST_POS + 2*i + 1];
    end
    assign dst[NUM_PORTS] = |cpu_bits;

    assign blocked   = s_axis_buffer_almost_full | s_axis_pifo_full;
    assign ok        = dst & ~blocked;
    assign meta_drop = s_axis_tuser[DROP_POS] | ~|dst;
    assign eligible  = (MCAST_MODE == 0) ? |ok : ~|(dst & blocked);

    // Decision cycle: a fresh packet in IDLE, or a re-evaluation while waiting.
    // Meta drops are only caught in IDLE; tuser is stable across a wait.
    assign meta_hit = s_axis_tvalid && (state == IDLE) && meta_drop;
    assign evaluate = s_axis_tvalid && (((state == IDLE) && !meta_drop) || (state == WAIT));
    assign go_enq   = evaluate && eligible;
    assign give_up  = evaluate && !eligible &&
                      ((WAIT_CYCLES == 0) || ((state == WAIT) && (timer == '0)));

    // Partial multicast charges the queues left out; a give-up charges every target.
    assign drop_inc = go_enq  ? ((MCAST_MODE == 0) ? (dst & ~ok) : '0) :
                      give_up ? dst : '0;

    assign s_axis_tready           = (state == ENQUEUE) || (state == DROP);
    assign m_axis_ctl_buffer_wr_en = ((state == ENQUEUE) && s_axis_tvalid) ? mask : '0;
    assign m_axis_ctl_pifo_in_en   = ((state == ENQUEUE) && s_axis_tvalid && first) ? mask : '0;

    // Packet FSM: decide once per packet, then stream the beats through or away.
    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            state <= IDLE;
            mask  <= '0;
            first <= 1'b0;
            timer <= '0;
        end else begin
            case (state)
                IDLE, WAIT: begin
                    if (!s_axis_tvalid) begin
                        state <= IDLE;
                    end else if (meta_hit) begin
                        state <= DROP;
                    end else if (go_enq) begin
                        state <= ENQUEUE;
                        mask  <= ok;
                        first <= 1'b1;
                    end else if (give_up) begin
                        state <= DROP;
                    end else if (state == IDLE) begin
                        state <= WAIT;
                        timer <= TIMER_INIT;
                    end else begin
                        timer <= timer - T_ONE;
                    end
                end
                ENQUEUE: begin
                    if (s_axis_tvalid) begin
                        first <= 1'b0;
                        if (s_axis_tlast) state <= IDLE;
                    end
                end
                DROP: begin
                    if (s_axis_tvalid && s_axis_tlast) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Per-queue drop counters; clear has priority over a same-cycle increment.
    for (genvar q = 0; q < QUEUE_NUM; q++) begin : g_drop
        logic [CNT_WIDTH-1:0] cnt;
        always_ff @(posedge axis_aclk) begin
            if (axis_reset || stat_clear) cnt <= '0;
            else if (drop_inc[q] && !(&cnt)) cnt <= cnt + C_ONE;
        end
        assign stat_drop_cnt[q*CNT_WIDTH +: CNT_WIDTH] = cnt;
    end

    // Meta-drop counter, saturating.
    always_ff @(posedge axis_aclk) begin
        if (axis_reset || stat_clear) stat_meta_drop_cnt <= '0;
        else if (meta_hit && !(&stat_meta_drop_cnt)) stat_meta_drop_cnt <= stat_meta_drop_cnt + C_ONE;
    end

    // Enqueue counter, bumped on entry to ENQUEUE, saturating.
    always_ff @(posedge axis_aclk) begin
        if (axis_reset || stat_clear) stat_enq_cnt <= '0;
        else if (go_enq && !(&stat_enq_cnt)) stat_enq_cnt <= stat_enq_cnt + C_ONE;
    end

endmodule

// File: tb/tb_enqueue_agent_v0_2.sv
// tb_enqueue_agent_v0_2
// Two agents side by side: instance 0 partial multicast with immediate drop,
// instance 1 all-or-nothing with a 3-cycle wait; both with 4-bit counters.
// A packet-level model predicts each decision and the counter effects.
module tb_enqueue_agent_v0_2;

    localparam int CMAX = 15;
    localparam int MODE  [2] = '{0, 1};
    localparam int WAITC [2] = '{0, 3};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, clr;
    logic         tvalid [2];
    logic         tlast  [2];
    logic [127:0] tuser  [2];
    logic [4:0]   af     [2];
    logic [4:0]   pf     [2];
    logic         tready [2];
    logic [4:0]   pen    [2];
    logic [4:0]   wen    [2];
    logic [19:0]  dcnt   [2];
    logic [3:0]   mcnt   [2];
    logic [3:0]   ecnt   [2];

    enqueue_agent_v0_2 #(.MCAST_MODE(0), .WAIT_CYCLES(0), .CNT_WIDTH(4)) u_dut0 (
        .axis_aclk(clk), .axis_reset(rst),
        .s_axis_tvalid(tvalid[0]), .s_axis_tready(tready[0]),
        .s_axis_tuser(tuser[0]), .s_axis_tlast(tlast[0]),
        .s_axis_buffer_almost_full(af[0]), .s_axis_pifo_full(pf[0]),
        .m_axis_ctl_pifo_in_en(pen[0]), .m_axis_ctl_buffer_wr_en(wen[0]),
        .stat_clear(clr), .stat_drop_cnt(dcnt[0]),
        .stat_meta_drop_cnt(mcnt[0]), .stat_enq_cnt(ecnt[0]));

    enqueue_agent_v0_2 #(.MCAST_MODE(1), .WAIT_CYCLES(3), .CNT_WIDTH(4)) u_dut1 (
        .axis_aclk(clk), .axis_reset(rst),
        .s_axis_tvalid(tvalid[1]), .s_axis_tready(tready[1]),
        .s_axis_tuser(tuser[1]), .s_axis_tlast(tlast[1]),
        .s_axis_buffer_almost_full(af[1]), .s_axis_pifo_full(pf[1]),
        .m_axis_ctl_pifo_in_en(pen[1]), .m_axis_ctl_buffer_wr_en(wen[1]),
        .stat_clear(clr), .stat_drop_cnt(dcnt[1]),
        .stat_meta_drop_cnt(mcnt[1]), .stat_enq_cnt(ecnt[1]));

    int total = 0;
    int bad   = 0;
    int m_drop [2][5];
    int m_meta [2];
    int m_enq  [2];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    function automatic int sat(input int x);
        return (x < CMAX) ? x + 1 : CMAX;
    endfunction

    task automatic model_zero();
        for (int d = 0; d < 2; d++) begin
            for (int q = 0; q < 5; q++) m_drop[d][q] = 0;
            m_meta[d] = 0;
            m_enq[d]  = 0;
        end
    endtask

    task automatic chk_cnt(input int d);
        for (int q = 0; q < 5; q++) chk("drop_cnt", dcnt[d][q*4 +: 4], 64'(m_drop[d][q]));
        chk("meta_cnt", mcnt[d], 64'(m_meta[d]));
        chk("enq_cnt",  ecnt[d], 64'(m_enq[d]));
    endtask

    // ports: one-hot physical ports, cpu: CPU dst bit, drop: meta drop bit
    function automatic logic [127:0] mk(input logic [3:0] ports, input logic cpu, input logic drop);
        logic [127:0] u;
        u = '0;
        for (int i = 0; i < 4; i++) u[24 + 2*i] = ports[i];
        u[25] = cpu;
        u[32] = drop;
        return u;
    endfunction

    // One packet on agent d. hold<0: random queue status at every decision
    // cycle; else af_fix/pf_fix for the first `hold` evaluations, then free.
    // gapmask<0: random tvalid gaps, else bit b puts a gap before beat b.
    task automatic send_pkt(input int d, input logic [127:0] user, input int nb,
                            input logic [4:0] af_fix, input logic [4:0] pf_fix,
                            input int hold, input int gapmask, input bit clr_dec);
        logic [4:0] dst, blk, ok, msk, loss;
        logic meta, elig, enq, is_meta, gap;
        int ev;
        bit done;
        dst = '0;
        for (int i = 0; i < 4; i++) begin
            dst[i] = user[24 + 2*i];
            dst[4] = dst[4] | user[25 + 2*i];
        end
        meta = user[32] | (dst == 5'b0);
        tuser[d] = user; tvalid[d] = 1'b1; tlast[d] = 1'b0;
        ev = 0; done = 0; enq = 0; is_meta = 0; msk = '0; loss = '0;
        while (!done) begin
            if (hold < 0) begin
                af[d] = 5'($urandom & $urandom);
                pf[d] = 5'($urandom & $urandom & $urandom);
            end else if (ev < hold) begin
                af[d] = af_fix; pf[d] = pf_fix;
            end else begin
                af[d] = '0; pf[d] = '0;
            end
            blk  = af[d] | pf[d];
            ok   = dst & ~blk;
            elig = (MODE[d] == 0) ? (ok != 0) : ((dst & blk) == 0);
            samp();
            chk("rdy_decide", tready[d], 0);
            chk("wen_decide", wen[d], 0);
            chk("pen_decide", pen[d], 0);
            if (ev == 0 && meta) begin
                done = 1; is_meta = 1;
            end else if (elig) begin
                done = 1; enq = 1; msk = ok;
                loss = (MODE[d] == 0) ? (dst & ~ok) : 5'b0;
            end else if (ev == WAITC[d]) begin
                done = 1; loss = dst;
            end else begin
                ev++;
            end
            if (done && clr_dec) clr = 1'b1;
            tick();
            clr = 1'b0;
            if (done) begin
                if (clr_dec) model_zero();
                else begin
                    for (int q = 0; q < 5; q++) if (loss[q]) m_drop[d][q] = sat(m_drop[d][q]);
                    if (is_meta) m_meta[d] = sat(m_meta[d]);
                    if (enq) m_enq[d] = sat(m_enq[d]);
                end
            end
        end
        for (int b = 0; b < nb; b++) begin
            gap = (gapmask < 0) ? ($urandom_range(3) == 0) : gapmask[b];
            if (gap) begin
                tvalid[d] = 1'b0;
                samp();
                chk("rdy_gap", tready[d], 1);
                chk("wen_gap", wen[d], 0);
                chk("pen_gap", pen[d], 0);
                tick();
            end
            tvalid[d] = 1'b1; tlast[d] = (b == nb - 1);
            af[d] = 5'($urandom); pf[d] = 5'($urandom);
            samp();
            chk("rdy_beat", tready[d], 1);
            chk("wen_beat", wen[d], enq ? msk : 5'b0);
            chk("pen_beat", pen[d], (enq && b == 0) ? msk : 5'b0);
            tick();
        end
        tvalid[d] = 1'b0; tlast[d] = 1'b0; af[d] = '0; pf[d] = '0;
        samp();
        chk_cnt(d);
        tick();
    endtask

    initial begin
        logic [127:0] u;
        for (int d = 0; d < 2; d++) begin
            tvalid[d] = 0; tlast[d] = 0; tuser[d] = '0; af[d] = '0; pf[d] = '0;
        end
        clr = 0;
        rst = 1;
        model_zero();
        repeat (3) tick();
        rst = 0;
        samp();
        for (int d = 0; d < 2; d++) begin
            chk("rst_rdy", tready[d], 0);
            chk("rst_wen", wen[d], 0);
            chk("rst_pen", pen[d], 0);
            chk_cnt(d);
        end
        tick();

        // unicast port 2, 3 beats, all free
        send_pkt(0, mk(4'b0100, 0, 0), 3, '0, '0, 0, 0, 0);
        // multicast 0,1,CPU with queue 1 almost full: partial vs all-or-nothing
        send_pkt(0, mk(4'b0011, 1, 0), 2, 5'b00010, '0, 100, 0, 0);
        send_pkt(1, mk(4'b0011, 1, 0), 2, 5'b00010, '0, 100, 0, 0);
        // wait mode: released in 2nd WAIT cycle, then held past the limit
        send_pkt(1, mk(4'b0001, 0, 0), 2, '0, 5'b00001, 2, 0, 0);
        send_pkt(1, mk(4'b0001, 0, 0), 3, '0, 5'b00001, 5, 0, 0);
        // drop bit, empty dst
        send_pkt(0, mk(4'b0100, 0, 1), 2, '0, '0, 0, 0, 0);
        send_pkt(1, mk(4'b0000, 0, 0), 2, '0, '0, 0, 0, 0);
        // valid gaps: after beat 0, and before beat 0
        send_pkt(0, mk(4'b1000, 0, 0), 3, '0, '0, 0, 32'b010, 0);
        send_pkt(1, mk(4'b1000, 0, 0), 3, '0, '0, 0, 32'b001, 0);

        // randomized traffic
        for (int n = 0; n < 150; n++) begin
            u = {$urandom, $urandom, $urandom, $urandom};
            u[31:24] = 8'($urandom);
            u[32] = ($urandom_range(7) == 0);
            send_pkt(n % 2 == 0 ? int'($urandom_range(1)) : 1 - int'($urandom_range(1)),
                     u, int'($urandom_range(4, 1)), '0, '0, -1, -1, 0);
        end

        // saturation: 17 meta drops on a 4-bit counter
        for (int n = 0; n < 17; n++) send_pkt(0, mk(4'b0001, 0, 1), 1, '0, '0, 0, 0, 0);
        samp();
        chk("meta_sat", mcnt[0], 15);
        tick();

        // clear in the same cycle as an increment
        send_pkt(0, mk(4'b0001, 0, 1), 1, '0, '0, 0, 0, 1);
        chk_cnt(1);

        // reset mid-packet
        send_pkt(0, mk(4'b0010, 0, 0), 1, '0, '0, 0, 0, 0);
        tuser[0] = mk(4'b0100, 0, 0); tvalid[0] = 1; tlast[0] = 0;
        tick();
        tick();
        rst = 1;
        tick();
        model_zero();
        samp();
        chk("midrst_rdy", tready[0], 0);
        chk("midrst_wen", wen[0], 0);
        chk("midrst_pen", pen[0], 0);
        chk_cnt(0);
        chk_cnt(1);
        rst = 0; tvalid[0] = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
